atomik_dna_vault: RTL and testbench
===================================

# atomik_dna_vault

Downstream consumer of the UART genome loader. Captures the 256-bit DNA, mutation period, seed and OTP policy when the loader ignites the core. Serves the DNA as a whitened byte stream over a valid/ready port. When the OTP policy is set, it zeroizes each byte as it is read and locks permanently after the last byte (burn-on-read).

## Interface
Parameters:
- DNA_BYTES, 32, number of DNA bytes; `dna_in` width is DNA_BYTES*8.
- LFSR_TAPS, 32'h80200003, Galois right-shift feedback mask.
- NULL_SEED, 32'hDEADBEEF, LFSR load value used when the seed is zero.

Ports:
- clk  in  1  system clock; the block uses this single clock.
- rst  in  1  reset, asynchronous, active-high.
- core_enable  in  1  loader ignite level; its rising edge triggers capture.
- loader_busy  in  1  loader mid-ingestion; aborts the block and clears it.
- dna_in  in  256  DNA from the loader.
- poly_freq  in  32  mutation period in clk cycles; 0 disables mutation.
- poly_seed  in  32  LFSR seed.
- otp_en  in  1  burn-on-read policy.
- rd_start  in  1  request one full stream; honoured only in ARMED.
- rd_valid  out  1  rd_data holds a byte.
- rd_ready  in  1  consumer accepts the byte.
- rd_data  out  8  DNA byte XOR whitening byte.
- rd_last  out  1  marks the final byte (index DNA_BYTES-1).
- armed  out  1  vault holds DNA and is readable.
- burned  out  1  OTP stream completed; vault is locked.
- mutate_tick  out  1  one-cycle pulse on each LFSR step.

## Operation
- States: EMPTY, ARMED, STREAM, BURNED.
- Capture happens on a core_enable rising edge (registered edge detect), in any state except BURNED:
  - latch dna_in, poly_freq and otp_en;
  - load LFSR with poly_seed, or with NULL_SEED if poly_seed==0;
  - clear the period counter and byte index;
  - go to ARMED.
- rd_start in ARMED goes to STREAM and presents byte 0 (dna[7:0]). Bytes follow in ascending order.
- Each presented byte sets rd_data = dna[idx] ^ lfsr[7:0], sampled in the presentation cycle and registered. rd_data, rd_last and rd_valid stay stable while rd_valid && !rd_ready.
- A handshake is rd_valid && rd_ready:
  - if otp latched, zero dna[idx];
  - if idx < DNA_BYTES-1, present idx+1 on the next cycle;
  - otherwise drop rd_valid and go to BURNED (otp) or ARMED (no otp).
- Mutation runs in ARMED and STREAM when the latched period is nonzero:
  - counter increments every cycle;
  - at counter == period-1: counter←0, LFSR steps, next state = lsb ? (lfsr>>1)^LFSR_TAPS : lfsr>>1;
  - mutate_tick is high in the cycle the new LFSR value is visible.
- A LFSR step in a presentation cycle does not affect that byte; the byte uses the pre-step value.
- loader_busy high in any state except BURNED: next cycle go to EMPTY, zero the DNA, drop rd_valid, clear armed.
- Priority when events coincide: rst > loader_busy > capture edge > rd_start/handshake.
- BURNED ignores everything except rst. The DNA is already all-zero in this state.
- rd_start outside ARMED is ignored and not queued.

## Timing
- Reset values:
  - outputs: rd_valid, rd_data, rd_last, armed, burned, mutate_tick all 0;
  - internals: state EMPTY, DNA 0, LFSR NULL_SEED, counter 0, edge-detect history 0.
- Capture edge visible at cycle N gives armed=1 at N+1.
- rd_start at cycle M gives rd_valid=1 with byte 0 at M+1.
- Full throughput: handshake at k gives the next byte at k+1. A 32-byte stream takes 32 cycles with rd_ready held high.
- Last handshake at k: rd_valid=0 at k+1; burned=1 at k+1 (otp); armed=0 at k+1 (otp only).
- armed is 1 in both ARMED and STREAM.
- Reset asserted mid-stream gives immediate (asynchronous) return to reset values.

## Structure
- Shared package `atomik_pkg`:
  - vault state enum;
  - LFSR_TAPS and NULL_SEED constants;
  - DNA_BYTES default.
- One sub-module, `atomik_mut_lfsr`:
  - period counter plus Galois LFSR, with load, enable and tick outputs;
  - reused by other polymorphic stages.

## Test plan
- Load with poly_seed=32'h12345600, poly_freq=0, otp=0, dna byte i = i; then rd_start with rd_ready=1.
  - Expect: bytes 0x00..0x1F on consecutive cycles, rd_last on 0x1F, back to ARMED.
  - A second read returns the same bytes.
- Same load with otp=1; read once.
  - Expect: identical stream, then burned=1 and armed=0.
  - Later rd_start and core_enable edges are ignored and rd_valid stays 0.
- poly_seed=0, poly_freq=4, dna all 0x00; rd_start with rd_ready=1.
  - Expect: mutate_tick every 4th cycle.
  - Expect: the first byte is 0xEF, and later bytes follow the LFSR sequence from DEADBEEF.
- Backpressure: rd_ready toggles 1,0,0,1 during the stream.
  - Expect: rd_data holds through the stalls with a mutation step inside the stall; no byte is skipped or duplicated.
- loader_busy pulses at byte 10 of an otp stream.
  - Expect: rd_valid=0 the next cycle, state EMPTY, burned=0.
  - A new capture edge re-arms with the new DNA.

Source files
------------

// File: rtl/atomik_pkg.sv
// Shared definitions for the atomik polymorphic core stages.
//   vault_state_e    : DNA vault FSM states
//   DefaultDnaBytes  : default DNA length in bytes
//   DefaultLfsrTaps  : Galois right-shift feedback mask
//   DefaultNullSeed  : LFSR load value substituted for an all-zero seed
package atomik_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StArmed,
    StStream,
    StBurned
  } vault_state_e;

  localparam int unsigned DefaultDnaBytes = 32;
  localparam logic [31:0] DefaultLfsrTaps = 32'h80200003;
  localparam logic [31:0] DefaultNullSeed = 32'hDEADBEEF;

endpackage

// File: rtl/atomik_mut_lfsr.sv
// Mutation engine: period counter driving a 32-bit Galois right-shift LFSR.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load LFSR with load_val (NULL_SEED if zero) and clear the counter
//   load_val  : seed value
//   enable    : counter/LFSR advance enable
//   period    : steps every `period` enabled cycles; 0 disables stepping
//   lfsr      : low OUT_BITS of the current LFSR state
//   tick      : one-cycle pulse in the cycle a new LFSR value is visible
module atomik_mut_lfsr
  import atomik_pkg::*;
#(
  parameter logic [31:0] LFSR_TAPS = DefaultLfsrTaps,
  parameter logic [31:0] NULL_SEED = DefaultNullSeed,
  parameter int unsigned OUT_BITS  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [31:0]         load_val,
  input  logic                enable,
  input  logic [31:0]         period,
  output logic [OUT_BITS-1:0] lfsr,
  output logic                tick
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic        tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    tick_d = 1'b0;
    if (load) begin
      cnt_d  = '0;
      lfsr_d = (load_val == '0) ? NULL_SEED : load_val;
    end else if (enable && (period != '0)) begin
      // >= keeps the counter from running away if it ever sits past the period
      if (cnt_q >= period - 32'd1) begin
        cnt_d  = '0;
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      lfsr_q <= NULL_SEED;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      tick_q <= tick_d;
    end
  end

  assign lfsr = lfsr_q[OUT_BITS-1:0];
  assign tick = tick_q;

endmodule

// File: rtl/atomik_dna_vault.sv
// DNA vault: captures the genome from the UART loader on core_enable rising edge and
// serves it as an LFSR-whitened byte stream over valid/ready. With the OTP policy
// latched, each byte is zeroized on handshake and the vault locks after the last byte.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   core_enable       : loader ignite level (rising edge captures)
//   loader_busy       : loader mid-ingestion; aborts and clears the vault
//   dna_in            : DNA_BYTES*8 genome, byte 0 in [7:0]
//   poly_freq         : mutation period in cycles (0 = off)
//   poly_seed         : LFSR seed (0 selects NULL_SEED)
//   otp_en            : burn-on-read policy
//   rd_start          : request one full stream (ARMED only)
//   rd_valid/rd_ready : byte handshake
//   rd_data, rd_last  : whitened byte, final-byte marker
//   armed, burned     : status
//   mutate_tick       : pulse on each LFSR step
module atomik_dna_vault
  import atomik_pkg::*;
#(
  parameter int unsigned DNA_BYTES = DefaultDnaBytes,
  parameter logic [31:0] LFSR_TAPS = DefaultLfsrTaps,
  parameter logic [31:0] NULL_SEED = DefaultNullSeed
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_enable,
  input  logic                   loader_busy,
  input  logic [DNA_BYTES*8-1:0] dna_in,
  input  logic [31:0]            poly_freq,
  input  logic [31:0]            poly_seed,
  input  logic                   otp_en,
  input  logic                   rd_start,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [7:0]             rd_data,
  output logic                   rd_last,
  output logic                   armed,
  output logic                   burned,
  output logic                   mutate_tick
);

  localparam int unsigned IdxW    = (DNA_BYTES > 1) ? $clog2(DNA_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DNA_BYTES - 1);

  vault_state_e                state_q, state_d;
  logic [DNA_BYTES-1:0][7:0]   dna_q, dna_d;
  logic [31:0]                 freq_q, freq_d;
  logic                        otp_q, otp_d;
  logic [IdxW-1:0]             idx_q, idx_d;
  logic                        en_hist_q;
  logic                        rd_valid_q, rd_valid_d;
  logic [7:0]                  rd_data_q, rd_data_d;
  logic                        rd_last_q, rd_last_d;

  logic [IdxW-1:0] idx_nxt;
  logic [7:0]      whiten;
  logic            capture;
  logic            lfsr_load;
  logic            lfsr_run;
  logic            live;

  assign live    = (state_q != StBurned);
  assign capture = core_enable & ~en_hist_q;
  assign idx_nxt = idx_q + IdxW'(1);

  assign lfsr_load = live && !loader_busy && capture;
  assign lfsr_run  = ((state_q == StArmed) || (state_q == StStream)) && !loader_busy;

  atomik_mut_lfsr #(
    .LFSR_TAPS (LFSR_TAPS),
    .NULL_SEED (NULL_SEED),
    .OUT_BITS  (8)
  ) u_mut_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (poly_seed),
    .enable   (lfsr_run),
    .period   (freq_q),
    .lfsr     (whiten),
    .tick     (mutate_tick)
  );

  always_comb begin
    state_d    = state_q;
    dna_d      = dna_q;
    freq_d     = freq_q;
    otp_d      = otp_q;
    idx_d      = idx_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;

    // BURNED is terminal: only rst leaves it
    if (live) begin
      if (loader_busy) begin
        state_d    = StEmpty;
        dna_d      = '0;
        idx_d      = '0;
        rd_valid_d = 1'b0;
        rd_data_d  = '0;
        rd_last_d  = 1'b0;
      end else if (capture) begin
        state_d    = StArmed;
        dna_d      = dna_in;
        freq_d     = poly_freq;
        otp_d      = otp_en;
        idx_d      = '0;
        rd_valid_d = 1'b0;
        rd_data_d  = '0;
        rd_last_d  = 1'b0;
      end else begin
        unique case (state_q)
          StArmed: begin
            if (rd_start) begin
              state_d    = StStream;
              idx_d      = '0;
              rd_valid_d = 1'b1;
              // whitening uses the pre-step LFSR value of this cycle
              rd_data_d  = dna_q[0] ^ whiten;
              rd_last_d  = (LastIdx == '0);
            end
          end
          StStream: begin
            if (rd_valid_q && rd_ready) begin
              if (otp_q) begin
                dna_d[idx_q] = '0;
              end
              if (idx_q != LastIdx) begin
                idx_d     = idx_nxt;
                rd_data_d = dna_q[idx_nxt] ^ whiten;
                rd_last_d = (idx_nxt == LastIdx);
              end else begin
                rd_valid_d = 1'b0;
                rd_data_d  = '0;
                rd_last_d  = 1'b0;
                state_d    = otp_q ? StBurned : StArmed;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      dna_q      <= '0;
      freq_q     <= '0;
      otp_q      <= 1'b0;
      idx_q      <= '0;
      en_hist_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dna_q      <= dna_d;
      freq_q     <= freq_d;
      otp_q      <= otp_d;
      idx_q      <= idx_d;
      en_hist_q  <= core_enable;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign armed    = (state_q == StArmed) || (state_q == StStream);
  assign burned   = (state_q == StBurned);

endmodule

// File: tb/tb_atomik_dna_vault.sv
module tb_atomik_dna_vault;

  localparam int unsigned NB = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            core_enable;
  logic            loader_busy;
  logic [NB*8-1:0] dna_in;
  logic [31:0]     poly_freq;
  logic [31:0]     poly_seed;
  logic            otp_en;
  logic            rd_start;
  logic            rd_valid;
  logic            rd_ready;
  logic [7:0]      rd_data;
  logic            rd_last;
  logic            armed;
  logic            burned;
  logic            mutate_tick;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  atomik_dna_vault dut (
    .clk         (clk),
    .rst         (rst),
    .core_enable (core_enable),
    .loader_busy (loader_busy),
    .dna_in      (dna_in),
    .poly_freq   (poly_freq),
    .poly_seed   (poly_seed),
    .otp_en      (otp_en),
    .rd_start    (rd_start),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .armed       (armed),
    .burned      (burned),
    .mutate_tick (mutate_tick)
  );

  typedef struct {
    logic [31:0] seed;
    logic [31:0] freq;
    logic        otp;
    logic [7:0]  base;
    logic [7:0]  stp;
    int          reads;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  function automatic logic [NB*8-1:0] mk_dna(input logic [7:0] base, input logic [7:0] stp);
    logic [NB*8-1:0] d;
    for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'(base + stp * 8'(i));
    return d;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    core_enable = 1'b0;
    loader_busy = 1'b0;
    dna_in = '0;
    poly_freq = '0;
    poly_seed = '0;
    otp_en = 1'b0;
    rd_start = 1'b0;
    rd_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Leaves the bench just after the capture edge (edge E0).
  task automatic capture(input logic [7:0] base, input logic [7:0] stp, input logic [31:0] freq,
                         input logic [31:0] seed, input logic otp);
    core_enable = 1'b0;
    tick();
    dna_in = mk_dna(base, stp);
    poly_freq = freq;
    poly_seed = seed;
    otp_en = otp;
    core_enable = 1'b1;
    tick();
  endtask

  // Full-throughput read; byte j is sampled at edge j+1 after the start request.
  task automatic read_stream(input string tag, input logic [7:0] base, input logic [7:0] stp,
                             input logic [31:0] seed, input logic [31:0] freq,
                             input logic otp, input bit chk_tick);
    logic [31:0] l;
    logic [7:0]  exp_b;
    int unsigned nsteps;
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int j = 0; j < NB; j++) begin
      l = (seed == 32'd0) ? 32'hDEADBEEF : seed;
      nsteps = (freq == 0) ? 0 : (j / freq);
      for (int s = 0; s < int'(nsteps); s++) l = lfsr_step(l);
      exp_b = 8'(base + stp * 8'(j)) ^ l[7:0];
      check({tag, " valid"}, {31'd0, rd_valid}, 32'd1);
      check({tag, " data"}, {24'd0, rd_data}, {24'd0, exp_b});
      check({tag, " last"}, {31'd0, rd_last}, (j == NB - 1) ? 32'd1 : 32'd0);
      if (chk_tick)
        check({tag, " tick"}, {31'd0, mutate_tick},
              (freq != 0 && ((j + 1) % freq) == 0) ? 32'd1 : 32'd0);
      tick();
    end
    check({tag, " end valid"}, {31'd0, rd_valid}, 32'd0);
    check({tag, " end armed"}, {31'd0, armed}, otp ? 32'd0 : 32'd1);
    check({tag, " end burned"}, {31'd0, burned}, otp ? 32'd1 : 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{seed: 32'h12345600, freq: 32'd0, otp: 1'b0, base: 8'h00, stp: 8'h01, reads: 2};
    vecs[1] = '{seed: 32'h12345600, freq: 32'd0, otp: 1'b1, base: 8'h00, stp: 8'h01, reads: 1};
    vecs[2] = '{seed: 32'h00000000, freq: 32'd4, otp: 1'b0, base: 8'h00, stp: 8'h00, reads: 1};
    vecs[3] = '{seed: 32'hA5A5A5A5, freq: 32'd0, otp: 1'b1, base: 8'h80, stp: 8'h03, reads: 1};

    // Reset values
    do_reset();
    check("rst rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst rd_data", {24'd0, rd_data}, 32'd0);
    check("rst rd_last", {31'd0, rd_last}, 32'd0);
    check("rst armed", {31'd0, armed}, 32'd0);
    check("rst burned", {31'd0, burned}, 32'd0);
    check("rst tick", {31'd0, mutate_tick}, 32'd0);

    // rd_start while EMPTY is ignored
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("empty rd_start", {31'd0, rd_valid}, 32'd0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      capture(vecs[v].base, vecs[v].stp, vecs[v].freq, vecs[v].seed, vecs[v].otp);
      check($sformatf("v%0d armed", v), {31'd0, armed}, 32'd1);
      check($sformatf("v%0d idle valid", v), {31'd0, rd_valid}, 32'd0);
      for (int r = 0; r < vecs[v].reads; r++)
        read_stream($sformatf("v%0d r%0d", v, r), vecs[v].base, vecs[v].stp, vecs[v].seed,
                    vecs[v].freq, vecs[v].otp, (r == 0));
      if (vecs[v].otp) begin
        // Locked: neither rd_start nor a fresh capture edge may revive it
        for (int c = 0; c < 4; c++) begin
          rd_start = c[0];
          core_enable = c[1];
          tick();
          check($sformatf("v%0d burn valid c%0d", v, c), {31'd0, rd_valid}, 32'd0);
          check($sformatf("v%0d burn flag c%0d", v, c), {31'd0, burned}, 32'd1);
          check($sformatf("v%0d burn armed c%0d", v, c), {31'd0, armed}, 32'd0);
        end
        rd_start = 1'b0;
      end
    end

    // Backpressure with a mutation step inside the stall (seed 0 -> DEADBEEF, period 4)
    do_reset();
    capture(8'h00, 8'h01, 32'd4, 32'd0, 1'b0);
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    check("bp b0", {24'd0, rd_data}, 32'hEF);
    tick();
    check("bp b1", {24'd0, rd_data}, 32'hEE);
    rd_ready = 1'b0;
    tick();
    check("bp stall1 data", {24'd0, rd_data}, 32'hEE);
    check("bp stall1 valid", {31'd0, rd_valid}, 32'd1);
    check("bp stall1 tick", {31'd0, mutate_tick}, 32'd0);
    tick();
    check("bp stall2 data", {24'd0, rd_data}, 32'hEE);
    check("bp stall2 tick", {31'd0, mutate_tick}, 32'd1);
    rd_ready = 1'b1;
    tick();
    check("bp b2", {24'd0, rd_data}, 32'h76);
    tick();
    check("bp b3", {24'd0, rd_data}, 32'h77);
    check("bp b3 last", {31'd0, rd_last}, 32'd0);
    rd_ready = 1'b0;

    // loader_busy abort at byte 10 of an OTP stream, then re-arm with new DNA
    do_reset();
    capture(8'h00, 8'h01, 32'd0, 32'h12345600, 1'b1);
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (10) tick();
    check("busy byte10", {24'd0, rd_data}, 32'h0A);
    loader_busy = 1'b1;
    tick();
    loader_busy = 1'b0;
    check("busy valid", {31'd0, rd_valid}, 32'd0);
    check("busy armed", {31'd0, armed}, 32'd0);
    check("busy burned", {31'd0, burned}, 32'd0);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("busy empty rd_start", {31'd0, rd_valid}, 32'd0);
    capture(8'h40, 8'h01, 32'd0, 32'h12345600, 1'b0);
    check("rearm armed", {31'd0, armed}, 32'd1);
    read_stream("rearm", 8'h40, 8'h01, 32'h12345600, 32'd0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a stream
    do_reset();
    capture(8'h10, 8'h01, 32'd0, 32'h12345600, 1'b0);
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("pre-rst data", {24'd0, rd_data}, 32'h11);
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", {31'd0, rd_valid}, 32'd0);
    check("async rst data", {24'd0, rd_data}, 32'd0);
    check("async rst armed", {31'd0, armed}, 32'd0);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
